cv32e40px_apu_arbiter: RTL and testbench
========================================

Name: cv32e40px_apu_arbiter

Overview:
Shares one APU/FPU instance (cv32e40px_fp_wrapper) between NUM_PORTS cores' APU interfaces.
- Arbitrates issue requests round-robin and forwards the winner's operands, op and flags.
- Records each issued port index in an in-order tag FIFO so every result goes back to the core that issued it.
- Sits between cluster cores and a shared FP wrapper; the APU must return results in issue order.

Parameters:
NUM_PORTS, 2, number of requesting cores (2..8)
TAG_DEPTH, 4, max in-flight operations; power of two, >= 2
APU_NARGS, 3, operands per request
APU_WOP, 6, op-code width
APU_NDSFLAGS, 15, downstream flag width
APU_NUSFLAGS, 5, upstream flag width

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous active-high reset
port_req_i  in  NUM_PORTS  per-port issue request
port_gnt_o  out  NUM_PORTS  per-port grant (one-hot or zero)
port_operands_i  in  NUM_PORTS*APU_NARGS*32  packed operands, port p at slice p
port_op_i  in  NUM_PORTS*APU_WOP  packed op-codes
port_flags_i  in  NUM_PORTS*APU_NDSFLAGS  packed downstream flags
port_rvalid_o  out  NUM_PORTS  per-port result valid (one-hot or zero)
port_result_o  out  32  result, broadcast to all ports
port_rflags_o  out  APU_NUSFLAGS  result flags, broadcast to all ports
apu_req_o  out  1  request to shared APU
apu_gnt_i  in  1  APU accepts request
apu_operands_o  out  APU_NARGS*32  winner operands
apu_op_o  out  APU_WOP  winner op
apu_flags_o  out  APU_NDSFLAGS  winner flags
apu_rvalid_i  in  1  APU result valid
apu_result_i  in  32  APU result
apu_rflags_i  in  APU_NUSFLAGS  APU result flags
outstanding_o  out  $clog2(TAG_DEPTH)+1  in-flight count
err_o  out  1  sticky protocol error

Behaviour:
- Reset (asserted any time, async):
  - RR pointer=0, FIFO empty, outstanding_o=0, err_o=0.
  - All port_gnt_o/port_rvalid_o=0, apu_req_o=0.
  - Any in-flight results arriving after reset are dropped.
- Arbitration (combinational):
  - Winner w = first requesting port scanning from RR pointer upward, wrapping at NUM_PORTS.
  - apu_req_o = (|port_req_i) & !full; full when count==TAG_DEPTH.
  - apu_operands_o/op/flags = port w slices; all zero when apu_req_o=0.
  - port_gnt_o[w] = apu_req_o & apu_gnt_i; other bits 0.
- Issue handshake: requester holds req, operands, op and flags stable until granted.
  - On grant: push w into FIFO; RR pointer <= (w+1) mod NUM_PORTS.
  - Pointer does not change without a grant.
  - Pointer is not advanced by a non-requesting port.
- Full: no request forwarded and no grant, even if a pop occurs the same cycle. Push resumes the cycle after count<TAG_DEPTH.
- Result:
  - On apu_rvalid_i with FIFO non-empty: pop head h; port_rvalid_o[h]=1.
  - port_result_o/port_rflags_o = apu inputs; zero latency (feature off).
- Simultaneous push and pop: both occur; count unchanged; ordering preserved.
- apu_rvalid_i with FIFO empty: ignored (no port_rvalid_o); err_o set to 1 until reset.
- Count width $clog2(TAG_DEPTH)+1; read/write pointers wrap modulo TAG_DEPTH.
- No combinational path from apu_rvalid_i to apu_req_o.

Optional Feature:
Macro CV32E40PX_APU_ARB_RESULT_REG_EN.
- Defined: port_rvalid_o, port_result_o and port_rflags_o are registered. Result latency is 1 cycle after apu_rvalid_i.
  - Registers reset to 0.
  - FIFO pop still occurs in the apu_rvalid_i cycle.
- Undefined: result path is combinational, zero latency.

Test Plan:
- Reset, no requests -> all outputs 0, outstanding_o=0, err_o=0.
- Ports 0 and 1 request together, apu_gnt_i=1 each cycle, apu_rvalid_i two cycles later -> grants 0,1,0,1; rvalids return to 0,1,0,1 in order; port_result_o matches apu_result_i (e.g. 0x3F800000).
- TAG_DEPTH=4, apu_rvalid_i held 0, port 1 requests continuously -> 4 grants, outstanding_o=4, apu_req_o=0.
  - Then one apu_rvalid_i -> port_rvalid_o=0b10, next cycle grant resumes.
- apu_rvalid_i pulse with empty FIFO -> no port_rvalid_o; err_o=1 and stays 1 until rst_i.
- Push and pop same cycle at outstanding_o=2 -> outstanding_o stays 2; head port receives rvalid.
- rst_i asserted mid-operation with 3 in flight -> outstanding_o=0 immediately; later apu_rvalid_i sets err_o.
  - With macro defined: same flows with rvalid delayed exactly 1 cycle.

Source files
------------

// File: rtl/cv32e40px_apu_arbiter_if.sv
// cv32e40px_apu_arbiter_if
//   Bundles the core-side issue/result signals and the shared-APU-side
//   signals of the APU arbiter.
//   slave  : arbiter view (consumes core requests and APU responses)
//   master : environment view (cores + shared APU, e.g. a testbench)
//   Core side : port_req_i, port_gnt_o, port_operands_i, port_op_i,
//               port_flags_i, port_rvalid_o, port_result_o, port_rflags_o
//   APU side  : apu_req_o, apu_gnt_i, apu_operands_o, apu_op_o, apu_flags_o,
//               apu_rvalid_i, apu_result_i, apu_rflags_i
interface cv32e40px_apu_arbiter_if #(
  parameter int NUM_PORTS    = 2,
  parameter int APU_NARGS    = 3,
  parameter int APU_WOP      = 6,
  parameter int APU_NDSFLAGS = 15,
  parameter int APU_NUSFLAGS = 5
);
  logic [NUM_PORTS-1:0]              port_req_i;
  logic [NUM_PORTS-1:0]              port_gnt_o;
  logic [NUM_PORTS*APU_NARGS*32-1:0] port_operands_i;
  logic [NUM_PORTS*APU_WOP-1:0]      port_op_i;
  logic [NUM_PORTS*APU_NDSFLAGS-1:0] port_flags_i;
  logic [NUM_PORTS-1:0]              port_rvalid_o;
  logic [31:0]                       port_result_o;
  logic [APU_NUSFLAGS-1:0]           port_rflags_o;

  logic                              apu_req_o;
  logic                              apu_gnt_i;
  logic [APU_NARGS*32-1:0]           apu_operands_o;
  logic [APU_WOP-1:0]                apu_op_o;
  logic [APU_NDSFLAGS-1:0]           apu_flags_o;
  logic                              apu_rvalid_i;
  logic [31:0]                       apu_result_i;
  logic [APU_NUSFLAGS-1:0]           apu_rflags_i;

  modport slave (
    input  port_req_i, port_operands_i, port_op_i, port_flags_i,
    output port_gnt_o, port_rvalid_o, port_result_o, port_rflags_o,
    output apu_req_o, apu_operands_o, apu_op_o, apu_flags_o,
    input  apu_gnt_i, apu_rvalid_i, apu_result_i, apu_rflags_i
  );

  modport master (
    output port_req_i, port_operands_i, port_op_i, port_flags_i,
    input  port_gnt_o, port_rvalid_o, port_result_o, port_rflags_o,
    input  apu_req_o, apu_operands_o, apu_op_o, apu_flags_o,
    output apu_gnt_i, apu_rvalid_i, apu_result_i, apu_rflags_i
  );
endinterface

// File: rtl/cv32e40px_apu_arbiter.sv
// cv32e40px_apu_arbiter
//   Shares one APU/FPU between NUM_PORTS cores. Issue requests are
//   arbitrated round-robin; the winning port index is pushed into an
//   in-order tag FIFO so each result (returned by the APU in issue order)
//   is steered back to the core that issued it.
// Ports:
//   clk_i, rst_i  : clock, asynchronous active-high reset
//   bus           : cv32e40px_apu_arbiter_if.slave (core side + APU side)
//   outstanding_o : number of operations in flight
//   err_o         : sticky, set by a result arriving with no tag in flight
// Optional feature:
//   CV32E40PX_APU_ARB_RESULT_REG_EN - when defined, port_rvalid_o,
//   port_result_o and port_rflags_o are registered (1 cycle latency);
//   otherwise the result path is combinational.
module cv32e40px_apu_arbiter #(
  parameter int NUM_PORTS    = 2,
  parameter int TAG_DEPTH    = 4,
  parameter int APU_NARGS    = 3,
  parameter int APU_WOP      = 6,
  parameter int APU_NDSFLAGS = 15,
  parameter int APU_NUSFLAGS = 5
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  cv32e40px_apu_arbiter_if.slave       bus,
  output logic [$clog2(TAG_DEPTH):0]   outstanding_o,
  output logic                         err_o
);
  localparam int PW  = $clog2(NUM_PORTS);
  localparam int PW1 = PW + 1;
  localparam int AW  = $clog2(TAG_DEPTH);
  localparam int CW  = AW + 1;
  localparam int OPW = APU_NARGS * 32;

  logic [PW-1:0] rr_ptr;
  logic [PW-1:0] win;
  logic          found;
  logic [PW1-1:0] cand;

  logic [PW-1:0] tag_mem [TAG_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          err;

  logic          full;
  logic          empty;
  logic          apu_req;
  logic          push;
  logic          pop;
  logic [PW-1:0] head;
  logic [NUM_PORTS-1:0] vld_p0;

  // Round-robin scan starting at rr_ptr, wrapping at NUM_PORTS.
  always_comb begin
    win   = '0;
    found = 1'b0;
    cand  = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      cand = {1'b0, rr_ptr} + PW1'(i);
      if (cand >= PW1'(NUM_PORTS)) cand = cand - PW1'(NUM_PORTS);
      if (!found && bus.port_req_i[cand[PW-1:0]]) begin
        win   = cand[PW-1:0];
        found = 1'b1;
      end
    end
  end

  assign full  = (count == CW'(TAG_DEPTH));
  assign empty = (count == '0);
  // full depends only on registered count, so apu_rvalid_i never reaches
  // apu_req_o combinationally; a same-cycle pop does not free a slot.
  assign apu_req = found & ~full & ~rst_i;
  assign push    = apu_req & bus.apu_gnt_i;
  assign pop     = bus.apu_rvalid_i & ~empty & ~rst_i;
  assign head    = tag_mem[rd_ptr];

  assign bus.apu_req_o = apu_req;

  always_comb begin
    bus.apu_operands_o = '0;
    bus.apu_op_o       = '0;
    bus.apu_flags_o    = '0;
    bus.port_gnt_o     = '0;
    if (apu_req) begin
      bus.apu_operands_o = bus.port_operands_i[win*OPW +: OPW];
      bus.apu_op_o       = bus.port_op_i[win*APU_WOP +: APU_WOP];
      bus.apu_flags_o    = bus.port_flags_i[win*APU_NDSFLAGS +: APU_NDSFLAGS];
    end
    if (push) bus.port_gnt_o[win] = 1'b1;
  end

  always_comb begin
    vld_p0 = '0;
    if (pop) vld_p0[head] = 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_ptr <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      err    <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
        rr_ptr <= (win == PW'(NUM_PORTS - 1)) ? '0 : win + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (bus.apu_rvalid_i && empty) err <= 1'b1;
    end
  end

  // Tag storage is data: only entries between rd_ptr and wr_ptr are read.
  always_ff @(posedge clk_i) begin
    if (push) tag_mem[wr_ptr] <= win;
  end

  assign outstanding_o = count;
  assign err_o         = err;

`ifdef CV32E40PX_APU_ARB_RESULT_REG_EN
  logic [NUM_PORTS-1:0]    vld_p1;
  logic [31:0]             result_p1;
  logic [APU_NUSFLAGS-1:0] rflags_p1;

  // Result stage boundary: tag already popped in the apu_rvalid_i cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vld_p1    <= '0;
      result_p1 <= '0;
      rflags_p1 <= '0;
    end else begin
      vld_p1    <= vld_p0;
      result_p1 <= bus.apu_result_i;
      rflags_p1 <= bus.apu_rflags_i;
    end
  end

  assign bus.port_rvalid_o = vld_p1;
  assign bus.port_result_o = result_p1;
  assign bus.port_rflags_o = rflags_p1;
`else
  assign bus.port_rvalid_o = vld_p0;
  assign bus.port_result_o = bus.apu_result_i;
  assign bus.port_rflags_o = bus.apu_rflags_i;
`endif

endmodule

// File: tb/tb_cv32e40px_apu_arbiter.sv
module tb_cv32e40px_apu_arbiter;
  logic       clk;
  logic       rst;
  logic [2:0] outstanding;
  logic       err;

  int n_assert = 0;
  int n_fail   = 0;

  logic [1:0]  prev_rv;
  logic [31:0] prev_res;
  logic [4:0]  prev_rfl;
  logic [31:0] cur_res;

  logic [95:0] ops0;
  logic [95:0] ops1;

  cv32e40px_apu_arbiter_if bus ();

  cv32e40px_apu_arbiter dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .bus          (bus),
    .outstanding_o(outstanding),
    .err_o        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [1:0] req, input logic gnt, input logic rv,
                       input logic [31:0] res);
    bus.port_req_i   = req;
    bus.apu_gnt_i    = gnt;
    bus.apu_rvalid_i = rv;
    bus.apu_result_i = res;
    bus.apu_rflags_i = res[4:0] ^ 5'h15;
    cur_res          = res;
    #1;
  endtask

  // Result-path check for the current cycle without advancing time.
  task automatic res_now(input logic [1:0] exp_rv);
`ifdef CV32E40PX_APU_ARB_RESULT_REG_EN
    chk("rvalid", bus.port_rvalid_o, prev_rv);
    chk("result", bus.port_result_o, prev_res);
    chk("rflags", bus.port_rflags_o, prev_rfl);
`else
    chk("rvalid", bus.port_rvalid_o, exp_rv);
    chk("result", bus.port_result_o, cur_res);
    chk("rflags", bus.port_rflags_o, cur_res[4:0] ^ 5'h15);
`endif
  endtask

  // Check result path, then advance to 1 time unit after the next edge.
  task automatic cycle(input logic [1:0] exp_rv);
    res_now(exp_rv);
    prev_rv  = exp_rv;
    prev_res = cur_res;
    prev_rfl = cur_res[4:0] ^ 5'h15;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_prev;
    prev_rv  = '0;
    prev_res = '0;
    prev_rfl = '0;
  endtask

  initial begin
    ops0 = {32'h0000_00A3, 32'h0000_00A2, 32'h0000_00A1};
    ops1 = {32'h0000_00B3, 32'h0000_00B2, 32'h0000_00B1};
    bus.port_operands_i = {ops1, ops0};
    bus.port_op_i       = {6'h2A, 6'h05};
    bus.port_flags_i    = {15'h2222, 15'h1111};
    bus.port_req_i      = '0;
    bus.apu_gnt_i       = 1'b0;
    bus.apu_rvalid_i    = 1'b0;
    bus.apu_result_i    = '0;
    bus.apu_rflags_i    = '0;
    cur_res = '0;
    clear_prev();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state, no requests
    drive(2'b00, 1'b0, 1'b0, 32'h0);
    chk("rst_gnt", bus.port_gnt_o, 2'b00);
    chk("rst_apu_req", bus.apu_req_o, 1'b0);
    chk("rst_operands", bus.apu_operands_o, 96'h0);
    chk("rst_op", bus.apu_op_o, 6'h0);
    chk("rst_outstanding", outstanding, 3'd0);
    chk("rst_err", err, 1'b0);
    cycle(2'b00);

    // Both ports request, results two cycles after issue
    drive(2'b11, 1'b1, 1'b0, 32'h0);
    chk("c0_gnt", bus.port_gnt_o, 2'b01);
    chk("c0_operands", bus.apu_operands_o, ops0);
    chk("c0_op", bus.apu_op_o, 6'h05);
    chk("c0_flags", bus.apu_flags_o, 15'h1111);
    cycle(2'b00);
    drive(2'b11, 1'b1, 1'b0, 32'h0);
    chk("c1_gnt", bus.port_gnt_o, 2'b10);
    chk("c1_operands", bus.apu_operands_o, ops1);
    chk("c1_op", bus.apu_op_o, 6'h2A);
    chk("c1_outstanding", outstanding, 3'd1);
    cycle(2'b00);
    drive(2'b11, 1'b1, 1'b1, 32'h3F80_0000);
    chk("c2_gnt", bus.port_gnt_o, 2'b01);
    chk("c2_outstanding", outstanding, 3'd2);
    cycle(2'b01);
    drive(2'b11, 1'b1, 1'b1, 32'h4000_0000);
    chk("c3_gnt", bus.port_gnt_o, 2'b10);
    chk("c3_pushpop_outstanding", outstanding, 3'd2);
    cycle(2'b10);
    drive(2'b00, 1'b0, 1'b1, 32'h4040_0000);
    chk("c4_apu_req", bus.apu_req_o, 1'b0);
    chk("c4_pushpop_outstanding", outstanding, 3'd2);
    cycle(2'b01);
    drive(2'b00, 1'b0, 1'b1, 32'h4080_0000);
    chk("c5_outstanding", outstanding, 3'd1);
    cycle(2'b10);
    drive(2'b00, 1'b0, 1'b0, 32'h0);
    chk("c6_outstanding", outstanding, 3'd0);
    chk("c6_err", err, 1'b0);
    cycle(2'b00);

    // Port 1 alone fills the tag FIFO
    for (int k = 0; k < 4; k++) begin
      drive(2'b10, 1'b1, 1'b0, 32'h0);
      chk("fill_gnt", bus.port_gnt_o, 2'b10);
      chk("fill_outstanding", outstanding, 3'(k));
      cycle(2'b00);
    end
    drive(2'b10, 1'b1, 1'b0, 32'h0);
    chk("full_outstanding", outstanding, 3'd4);
    chk("full_apu_req", bus.apu_req_o, 1'b0);
    chk("full_gnt", bus.port_gnt_o, 2'b00);
    chk("full_operands", bus.apu_operands_o, 96'h0);
    cycle(2'b00);
    drive(2'b10, 1'b1, 1'b1, 32'h40A0_0000);
    chk("full_pop_apu_req", bus.apu_req_o, 1'b0);
    chk("full_pop_gnt", bus.port_gnt_o, 2'b00);
    cycle(2'b10);
    drive(2'b10, 1'b1, 1'b0, 32'h0);
    chk("resume_outstanding", outstanding, 3'd3);
    chk("resume_apu_req", bus.apu_req_o, 1'b1);
    chk("resume_gnt", bus.port_gnt_o, 2'b10);
    cycle(2'b00);
    drive(2'b00, 1'b0, 1'b1, 32'h40C0_0000);
    chk("drain_outstanding", outstanding, 3'd4);
    cycle(2'b10);

    // Asynchronous reset with 3 in flight
    drive(2'b11, 1'b1, 1'b0, 32'h0);
    chk("pre_rst_outstanding", outstanding, 3'd3);
    chk("pre_rst_gnt", bus.port_gnt_o, 2'b01);
    res_now(2'b00);
    rst = 1'b1;
    #1;
    chk("mid_rst_outstanding", outstanding, 3'd0);
    chk("mid_rst_apu_req", bus.apu_req_o, 1'b0);
    chk("mid_rst_gnt", bus.port_gnt_o, 2'b00);
    chk("mid_rst_rvalid", bus.port_rvalid_o, 2'b00);
    chk("mid_rst_err", err, 1'b0);
    drive(2'b00, 1'b0, 1'b0, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    clear_prev();

    // Result arriving with nothing in flight
    drive(2'b00, 1'b0, 1'b1, 32'h0000_1234);
    chk("late_err_before", err, 1'b0);
    cycle(2'b00);
    drive(2'b00, 1'b0, 1'b0, 32'h0);
    chk("late_err_set", err, 1'b1);
    chk("late_outstanding", outstanding, 3'd0);
    cycle(2'b00);
    drive(2'b00, 1'b0, 1'b0, 32'h0);
    chk("err_sticky", err, 1'b1);
    cycle(2'b00);
    rst = 1'b1;
    #1;
    chk("err_cleared", err, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
